wb_regfile: RTL and testbench



---
 rtl/wb_regfile_pkg.sv | 24 ++
 rtl/wb_regfile_bypass.sv | 36 +++
 rtl/wb_regfile.sv | 98 +++++++++
 tb/tb_wb_regfile.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared types and encodings for the Y86 write-back register file.
//   WORD_W / BYTE_W : datapath and ID/icode widths
//   RNONE           : "no destination" register ID
//   IHALT / INOP    : instruction codes that affect retire/halt behaviour
//   state_t         : halt state machine encoding
package wb_regfile_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned REG_ID_W = 4;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [BYTE_W-1:0] byte_t;

    localparam byte_t RNONE = 8'h0F;
    localparam byte_t IHALT = 8'h00;
    localparam byte_t INOP  = 8'h01;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

endpackage

// File: rtl/wb_regfile_bypass.sv
// One decode read port: out-of-range IDs read as zero, otherwise the
// pending M write wins over the pending E write, which wins over storage.
// This mirrors commit priority so the read equals the post-edge content.
//   src    : register ID being read
//   we_m/dst_m/val_m, we_e/dst_e/val_e : pending write-back ports
//   stored : storage content at src
//   rval   : resolved read data (combinational)
module wb_regfile_bypass
    import wb_regfile_pkg::*;
#(
    parameter int unsigned NREGS = 8
) (
    input  logic [BYTE_W-1:0] src,
    input  logic              we_m,
    input  logic [BYTE_W-1:0] dst_m,
    input  logic [WORD_W-1:0] val_m,
    input  logic              we_e,
    input  logic [BYTE_W-1:0] dst_e,
    input  logic [WORD_W-1:0] val_e,
    input  logic [WORD_W-1:0] stored,
    output logic [WORD_W-1:0] rval
);

    localparam logic [BYTE_W-1:0] NREGS_B = BYTE_W'(NREGS);

    always_comb begin
        rval = stored;
        if (src >= NREGS_B)
            rval = '0;
        else if (we_m && (src == dst_m))
            rval = val_m;
        else if (we_e && (src == dst_e))
            rval = val_e;
    end

endmodule

// File: rtl/wb_regfile.sv
// Y86 write-back register file: commits valE/valM, serves two bypassed
// decode read ports, keeps a sticky halt flag and a retired counter.
//   clk, rst          : clock, synchronous active-high reset
//   wb_icode          : icode in write-back (INOP = bubble, IHALT = halt)
//   wb_valE/wb_dstE   : ALU result and its destination
//   wb_valM/wb_dstM   : memory result and its destination (wins on tie)
//   wb_stall          : freezes all state and disables bypass
//   d_srcA/d_srcB     : read IDs; d_rvalA/d_rvalB combinational read data
//   halted            : sticky halt flag
//   retired           : count of retired non-bubble instructions
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int unsigned NREGS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] wb_icode,
    input  logic [WORD_W-1:0] wb_valE,
    input  logic [WORD_W-1:0] wb_valM,
    input  logic [BYTE_W-1:0] wb_dstE,
    input  logic [BYTE_W-1:0] wb_dstM,
    input  logic              wb_stall,
    input  logic [BYTE_W-1:0] d_srcA,
    input  logic [BYTE_W-1:0] d_srcB,
    output logic [WORD_W-1:0] d_rvalA,
    output logic [WORD_W-1:0] d_rvalB,
    output logic              halted,
    output logic [WORD_W-1:0] retired
);

    localparam int unsigned       IDX_W   = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [BYTE_W-1:0] NREGS_B = BYTE_W'(NREGS);

    logic [WORD_W-1:0] regs [NREGS];
    logic [WORD_W-1:0] count;
    state_t            state;
    logic              active;
    logic              we_e;
    logic              we_m;
    logic [WORD_W-1:0] stored_a;
    logic [WORD_W-1:0] stored_b;

    assign halted  = (state == HALTED);
    assign retired = count;

    // Nothing moves while stalled or after HALT has retired.
    assign active = !wb_stall && !halted;
    assign we_e   = (wb_dstE < NREGS_B) && active;
    assign we_m   = (wb_dstM < NREGS_B) && active;

    // Out-of-range IDs are masked to zero inside the bypass.
    assign stored_a = regs[IDX_W'(d_srcA)];
    assign stored_b = regs[IDX_W'(d_srcB)];

    // Storage, retire counter and halt FSM; M is written last so it wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
            count <= '0;
            state <= RUN;
        end else begin
            if (we_e) regs[IDX_W'(wb_dstE)] <= wb_valE;
            if (we_m) regs[IDX_W'(wb_dstM)] <= wb_valM;
            if (active && (wb_icode != INOP)) count <= count + WORD_W'(1);
            case (state)
                RUN:     if (!wb_stall && (wb_icode == IHALT)) state <= HALTED;
                HALTED:  state <= HALTED;
                default: state <= RUN;
            endcase
        end
    end

    wb_regfile_bypass #(.NREGS(NREGS)) u_port_a (
        .src    (d_srcA),
        .we_m   (we_m),
        .dst_m  (wb_dstM),
        .val_m  (wb_valM),
        .we_e   (we_e),
        .dst_e  (wb_dstE),
        .val_e  (wb_valE),
        .stored (stored_a),
        .rval   (d_rvalA)
    );

    wb_regfile_bypass #(.NREGS(NREGS)) u_port_b (
        .src    (d_srcB),
        .we_m   (we_m),
        .dst_m  (wb_dstM),
        .val_m  (wb_valM),
        .we_e   (we_e),
        .dst_e  (wb_dstE),
        .val_e  (wb_valE),
        .stored (stored_b),
        .rval   (d_rvalB)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: the driver pushes expected port values
// from an architectural model; a negedge monitor pops and compares.
module tb_wb_regfile;
    import wb_regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  wb_icode, wb_dstE, wb_dstM, d_srcA, d_srcB;
    logic [31:0] wb_valE, wb_valM, d_rvalA, d_rvalB, retired;
    logic        wb_stall, halted;

    always #5 clk = ~clk;

    wb_regfile #(.NREGS(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_icode (wb_icode),
        .wb_valE  (wb_valE),
        .wb_valM  (wb_valM),
        .wb_dstE  (wb_dstE),
        .wb_dstM  (wb_dstM),
        .wb_stall (wb_stall),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .d_rvalA  (d_rvalA),
        .d_rvalB  (d_rvalB),
        .halted   (halted),
        .retired  (retired)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ret;
        logic        h;
        int          id;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int          seq   = 0;

    // Architectural model: eight registers, retired count, halt flag.
    logic [31:0] m_regs [8];
    logic [31:0] m_ret;
    logic        m_halt;

    task automatic chk(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s item=%0d got=%h expected=%h", name, id, act, exp);
        end
    endtask

    // Monitor: DUT outputs are compared mid-cycle, away from the edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("rvalA",   e.id, d_rvalA, e.a);
            chk("rvalB",   e.id, d_rvalB, e.b);
            chk("retired", e.id, retired, e.ret);
            chk("halted",  e.id, 32'(halted), 32'(e.h));
        end
    end

    // One cycle of stimulus: drive, predict, then advance the model.
    task automatic cyc(input logic r, input logic [7:0] ic, input logic [7:0] de,
                       input logic [31:0] ve, input logic [7:0] dm, input logic [31:0] vm,
                       input logic st, input logic [7:0] sa, input logic [7:0] sb);
        logic [31:0] nx [8];
        bit          live;
        exp_t        e;
        rst = r; wb_icode = ic; wb_dstE = de; wb_valE = ve; wb_dstM = dm;
        wb_valM = vm; wb_stall = st; d_srcA = sa; d_srcB = sb;
        live = !st && !m_halt;
        // A read returns what the register will hold after this edge.
        for (int i = 0; i < 8; i++) nx[i] = m_regs[i];
        if (live && de < 8) nx[de[2:0]] = ve;
        if (live && dm < 8) nx[dm[2:0]] = vm;
        e.a   = (sa < 8) ? nx[sa[2:0]] : 32'h0;
        e.b   = (sb < 8) ? nx[sb[2:0]] : 32'h0;
        e.ret = m_ret;
        e.h   = m_halt;
        e.id  = seq++;
        q.push_back(e);
        if (r) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
            m_ret  = 32'h0;
            m_halt = 1'b0;
        end else if (live) begin
            for (int i = 0; i < 8; i++) m_regs[i] = nx[i];
            if (ic != INOP) m_ret = m_ret + 32'h1;
            if (ic == IHALT) m_halt = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [7:0] sa, input logic [7:0] sb);
        cyc(1'b0, INOP, RNONE, 32'h0, RNONE, 32'h0, 1'b0, sa, sb);
    endtask

    function automatic logic [7:0] pick_id();
        case ($urandom_range(0, 3))
            0, 1:    return 8'($urandom_range(0, 7));
            2:       return 8'($urandom_range(8, 15));
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic logic [7:0] pick_icode();
        case ($urandom_range(0, 9))
            0:       return IHALT;
            1, 2, 3: return INOP;
            4, 5:    return 8'h30;
            6, 7:    return 8'h60;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        int guard;
        for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
        m_ret = 32'h0; m_halt = 1'b0;
        rst = 1'b1; wb_icode = INOP; wb_dstE = RNONE; wb_dstM = RNONE;
        wb_valE = 32'h0; wb_valM = 32'h0; wb_stall = 1'b0; d_srcA = 8'h0; d_srcB = 8'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state on every ID plus out-of-range IDs.
        for (int i = 0; i < 8; i += 2) idle(8'(i), 8'(i + 1));
        idle(RNONE, 8'h08);

        // E-port write with same-cycle bypass, then from storage.
        cyc(1'b0, 8'h30, 8'h02, 32'h1234, RNONE, 32'h0, 1'b0, 8'h02, 8'h03);
        idle(8'h02, 8'h03);

        // Both ports on one register: M wins.
        cyc(1'b0, 8'h50, 8'h05, 32'hAAAA, 8'h05, 32'hBBBB, 1'b0, 8'h05, 8'h02);
        idle(8'h05, 8'h05);

        // Stall holds state and disables bypass; release commits.
        repeat (3) cyc(1'b0, 8'h30, 8'h01, 32'h7, RNONE, 32'h0, 1'b1, 8'h01, 8'h02);
        cyc(1'b0, 8'h30, 8'h01, 32'h7, RNONE, 32'h0, 1'b0, 8'h01, 8'h05);
        idle(8'h01, 8'h02);

        // Three real instructions, two bubbles, HALT, then a blocked write.
        cyc(1'b1, INOP, RNONE, 32'h0, RNONE, 32'h0, 1'b0, 8'h01, 8'h02);
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 8'h60, RNONE, 32'h0, RNONE, 32'h0, 1'b0, 8'h03, 8'h00);
        repeat (2) idle(8'h03, 8'h00);
        cyc(1'b0, IHALT, RNONE, 32'h0, RNONE, 32'h0, 1'b0, 8'h03, 8'h00);
        cyc(1'b0, 8'h30, 8'h03, 32'h55, 8'h04, 32'h66, 1'b0, 8'h03, 8'h04);
        idle(8'h03, 8'h04);
        cyc(1'b1, 8'h30, 8'h03, 32'h55, RNONE, 32'h0, 1'b0, 8'h03, 8'h04);
        idle(8'h03, 8'h04);

        // Counter wrap: preload just below the wrap point.
        force dut.count = 32'hFFFF_FFFF;
        #1;
        release dut.count;
        m_ret = 32'hFFFF_FFFF;
        cyc(1'b0, 8'h20, 8'h06, 32'h99, RNONE, 32'h0, 1'b0, 8'h06, 8'h06);
        idle(8'h06, 8'h00);

        // Randomised traffic with occasional stall, halt and reset.
        for (int n = 0; n < 400; n++) begin
            logic r;
            r = ($urandom_range(0, 19) == 0) || (m_halt && $urandom_range(0, 3) == 0);
            cyc(r, pick_icode(), pick_id(), $urandom, pick_id(), $urandom,
                ($urandom_range(0, 4) == 0), pick_id(), pick_id());
        end

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d expected=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
